qupls_regfile_rdarb: RTL and testbench

- Read-side companion to the register-file write router: arbitrates up to NREQ operand-read requests from issue/functional-unit slots onto NPORT physical register-file read ports, then returns read data to each requester.
- Requests with identical physical register numbers are coalesced onto one port.
- Excess requests are held off with a per-requester ack and a global stall.
- Sits between the issue/operand-fetch stage and the physical register file.

---
 rtl/qupls_regfile_rdarb.sv | 145 ++++++++++++++
 tb/tb_qupls_regfile_rdarb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/qupls_regfile_rdarb.sv
// Register-file read arbiter: packs up to NREQ operand-read requests onto
// NPORT RF read ports each cycle, merges requests for the same preg onto one
// port, and steers the RF data back to every requester three cycles later.

// Per-requester response register: picks the port this slot was routed to.
module qupls_regfile_rdarb_slot #(
    parameter int NPORT  = 4,
    parameter int DATA_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NPORT-1:0]              hit,
    input  logic [NPORT-1:0][DATA_W-1:0]  rfport_data,
    output logic                          rsp_v,
    output logic [DATA_W-1:0]             rsp_data
);
    logic [DATA_W-1:0] data_sel;

    // A slot is routed from at most one port per cycle, so a plain OR-mux works.
    always_comb begin
        data_sel = '0;
        for (int k = 0; k < NPORT; k++)
            if (hit[k]) data_sel = rfport_data[k];
    end

    // One-cycle valid pulse; data holds when nothing is routed here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_v    <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_v <= |hit;
            if (|hit) rsp_data <= data_sel;
        end
    end
endmodule

module qupls_regfile_rdarb #(
    parameter int NREQ   = 12,
    parameter int NPORT  = 4,
    parameter int PREG_W = 9,
    parameter int DATA_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_v,
    input  logic [NREQ-1:0][PREG_W-1:0]   req_preg,
    output logic [NREQ-1:0]               req_ack,
    output logic                          stall,
    output logic [NPORT-1:0]              rfport_v,
    output logic [NPORT-1:0][PREG_W-1:0]  rfport_preg,
    input  logic [NPORT-1:0][DATA_W-1:0]  rfport_data,
    output logic [NREQ-1:0]               rsp_v,
    output logic [NREQ-1:0][DATA_W-1:0]   rsp_data
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]                ptr, ptr_nxt;
    logic [NPORT-1:0]                sel_v;
    logic [NPORT-1:0][PREG_W-1:0]    sel_preg;
    logic [NPORT-1:0][NREQ-1:0]      route_d, route_s1, route_s2;
    logic [NREQ-1:0][NPORT-1:0]      slot_hit;

    // Round-robin scan from ptr: reuse a port holding the same preg, else
    // claim the next free port; the first slot left over becomes the new ptr.
    always_comb begin
        int   idx;
        logic hit;
        logic found;
        idx      = 0;
        hit      = 1'b0;
        found    = 1'b0;
        sel_v    = '0;
        sel_preg = '0;
        route_d  = '0;
        req_ack  = '0;
        ptr_nxt  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            hit = 1'b0;
            if (req_v[idx]) begin
                // Used ports are contiguous from 0, so the first free port
                // seen is the next one to allocate.
                for (int k = 0; k < NPORT; k++) begin
                    if (!hit) begin
                        if (sel_v[k] && sel_preg[k] == req_preg[idx]) begin
                            hit            = 1'b1;
                            route_d[k][idx] = 1'b1;
                        end else if (!sel_v[k]) begin
                            hit             = 1'b1;
                            sel_v[k]        = 1'b1;
                            sel_preg[k]     = req_preg[idx];
                            route_d[k][idx] = 1'b1;
                        end
                    end
                end
                if (hit) begin
                    req_ack[idx] = 1'b1;
                end else if (!found) begin
                    found   = 1'b1;
                    ptr_nxt = PTR_W'(idx);
                end
            end
        end
    end

    assign stall = |(req_v & ~req_ack);

    // RF address issue, route-mask pipeline (follows RF latency) and pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            rfport_v    <= '0;
            rfport_preg <= '0;
            route_s1    <= '0;
            route_s2    <= '0;
        end else begin
            ptr         <= ptr_nxt;
            rfport_v    <= sel_v;
            rfport_preg <= sel_preg;
            route_s1    <= route_d;
            route_s2    <= route_s1;
        end
    end

    // Transpose port-major route masks into per-slot port hits.
    always_comb begin
        slot_hit = '0;
        for (int j = 0; j < NREQ; j++)
            for (int k = 0; k < NPORT; k++)
                slot_hit[j][k] = route_s2[k][j];
    end

    for (genvar j = 0; j < NREQ; j++) begin : g_slot
        qupls_regfile_rdarb_slot #(.NPORT(NPORT), .DATA_W(DATA_W)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .hit         (slot_hit[j]),
            .rfport_data (rfport_data),
            .rsp_v       (rsp_v[j]),
            .rsp_data    (rsp_data[j])
        );
    end
endmodule

// File: tb/tb_qupls_regfile_rdarb.sv
// Scoreboard bench for qupls_regfile_rdarb: directed request patterns push
// expected responses; a negedge monitor pops and compares rsp_v/rsp_data.
module tb_qupls_regfile_rdarb;
    localparam int NREQ = 12, NPORT = 4, PREG_W = 9, DATA_W = 64;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]               req_v;
    logic [NREQ-1:0][PREG_W-1:0]   req_preg;
    logic [NREQ-1:0]               req_ack;
    logic                          stall;
    logic [NPORT-1:0]              rfport_v;
    logic [NPORT-1:0][PREG_W-1:0]  rfport_preg;
    logic [NPORT-1:0][DATA_W-1:0]  rfport_data;
    logic [NREQ-1:0]               rsp_v;
    logic [NREQ-1:0][DATA_W-1:0]   rsp_data;

    typedef struct {
        int                        cyc;
        logic [NREQ-1:0]           v;
        logic [NREQ-1:0][DATA_W-1:0] d;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   n_checks = 0, n_errors = 0, cyc = 0;

    always #5 clk = ~clk;

    qupls_regfile_rdarb #(.NREQ(NREQ), .NPORT(NPORT), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req_v(req_v), .req_preg(req_preg), .req_ack(req_ack),
        .stall(stall), .rfport_v(rfport_v), .rfport_preg(rfport_preg),
        .rfport_data(rfport_data), .rsp_v(rsp_v), .rsp_data(rsp_data)
    );

    function automatic logic [DATA_W-1:0] rfv(input logic [PREG_W-1:0] p);
        return 64'hDA7A_0000_0000_0000 + 64'(p) * 64'h0000_0001_0001_0001;
    endfunction

    // Register file model: data one cycle after the address.
    always @(posedge clk)
        for (int k = 0; k < NPORT; k++) rfport_data[k] <= rfv(rfport_preg[k]);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Expected response for mask m, three cycles after the current cycle.
    task automatic push(input logic [NREQ-1:0] m);
        exp_t e;
        e.cyc = cyc + 3;
        e.v   = m;
        e.d   = '0;
        for (int j = 0; j < NREQ; j++) if (m[j]) e.d[j] = rfv(req_preg[j]);
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rsp_v != '0) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_errors++;
                    $display("FAIL rsp_unexpected: got rsp_v=%h at cycle %0d want none", rsp_v, cyc);
                end else begin
                    logic bad;
                    me  = sbq.pop_front();
                    bad = (me.cyc != cyc) || (rsp_v !== me.v);
                    for (int j = 0; j < NREQ; j++)
                        if (me.v[j] && rsp_data[j] !== me.d[j]) bad = 1'b1;
                    if (bad) begin
                        n_errors++;
                        $display("FAIL rsp: got rsp_v=%h cycle %0d slot0 %h want rsp_v=%h cycle %0d slot0 %h",
                                 rsp_v, cyc, rsp_data[0], me.v, me.cyc, me.d[0]);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                n_checks++;
                n_errors++;
                me = sbq.pop_front();
                $display("FAIL rsp_missing: got rsp_v=0 at cycle %0d want %h", cyc, me.v);
            end
        end
    end

    initial begin
        logic [NREQ-1:0] fair [4];
        fair[0] = 12'h00F; fair[1] = 12'h0F0; fair[2] = 12'hF00; fair[3] = 12'h00F;

        // Reset with random inputs: outputs clear asynchronously.
        rst = 1'b1;
        req_v = 12'($urandom);
        for (int j = 0; j < NREQ; j++) req_preg[j] = PREG_W'($urandom);
        #2 rst = 1'b0;
        #1;
        chk("rst_rfport_v", 64'(rfport_v), 64'h0);
        chk("rst_rsp_v", 64'(rsp_v), 64'h0);
        chk("rst_rsp_data", 64'(|rsp_data), 64'h0);
        repeat (2) @(posedge clk);
        #1 req_v = '0;
        @(negedge clk) rst = 1'b1;
        chk("rst_ptr", 64'(dut.ptr), 64'h0);

        // Three distinct pregs, all fit.
        tick();
        req_v = 12'h007;
        req_preg[0] = 9'h010; req_preg[1] = 9'h011; req_preg[2] = 9'h012;
        @(negedge clk);
        chk("t2_ack", 64'(req_ack), 64'h007);
        chk("t2_stall", 64'(stall), 64'h0);
        push(12'h007);
        tick();
        req_v = '0;
        @(negedge clk);
        chk("t2_rfport_v", 64'(rfport_v), 64'h7);
        chk("t2_port0", 64'(rfport_preg[0]), 64'h010);
        chk("t2_port1", 64'(rfport_preg[1]), 64'h011);
        chk("t2_port2", 64'(rfport_preg[2]), 64'h012);
        chk("t2_port3", 64'(rfport_preg[3]), 64'h000);

        // Six distinct pregs: overflow, then remainder next cycle.
        tick();
        req_v = 12'h03F;
        for (int j = 0; j < 6; j++) req_preg[j] = PREG_W'(9'h040 + j);
        @(negedge clk);
        chk("t3_ack0", 64'(req_ack), 64'h00F);
        chk("t3_stall0", 64'(stall), 64'h1);
        push(12'h00F);
        tick();
        req_v = 12'h030;
        @(negedge clk);
        chk("t3_ptr", 64'(dut.ptr), 64'h4);
        chk("t3_ack1", 64'(req_ack), 64'h030);
        chk("t3_stall1", 64'(stall), 64'h0);
        push(12'h030);
        tick();
        req_v = '0;
        @(negedge clk);
        chk("t3_rfport_v", 64'(rfport_v), 64'h3);
        chk("t3_port0", 64'(rfport_preg[0]), 64'h044);
        chk("t3_port1", 64'(rfport_preg[1]), 64'h045);
        repeat (5) tick();

        // Reset to bring ptr back to 0.
        rst = 1'b0;
        tick();
        rst = 1'b1;

        // Coalescing: slots 0 and 2 share preg 0x21.
        tick();
        req_v = 12'h01F;
        req_preg[0] = 9'h021; req_preg[1] = 9'h030; req_preg[2] = 9'h021;
        req_preg[3] = 9'h031; req_preg[4] = 9'h032;
        @(negedge clk);
        chk("t4_ack", 64'(req_ack), 64'h01F);
        chk("t4_stall", 64'(stall), 64'h0);
        push(12'h01F);
        tick();
        req_v = '0;
        @(negedge clk);
        chk("t4_rfport_v", 64'(rfport_v), 64'hF);
        chk("t4_port0", 64'(rfport_preg[0]), 64'h021);
        chk("t4_port1", 64'(rfport_preg[1]), 64'h030);
        chk("t4_port2", 64'(rfport_preg[2]), 64'h031);
        chk("t4_port3", 64'(rfport_preg[3]), 64'h032);

        // Fairness: all slots live continuously.
        tick();
        req_v = 12'hFFF;
        for (int j = 0; j < NREQ; j++) req_preg[j] = PREG_W'(9'h050 + j);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t5_ack%0d", i), 64'(req_ack), 64'(fair[i]));
            chk($sformatf("t5_stall%0d", i), 64'(stall), 64'h1);
            push(fair[i]);
            tick();
        end
        req_v = '0;
        repeat (6) tick();

        // Reset mid-flight discards the in-flight read.
        req_v = 12'h001;
        req_preg[0] = 9'h077;
        @(negedge clk);
        chk("t6_ack", 64'(req_ack), 64'h001);
        tick();
        rst = 1'b0;
        req_v = '0;
        @(negedge clk);
        chk("t6_rfport_v", 64'(rfport_v), 64'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t6_rsp_v%0d", i), 64'(rsp_v), 64'h0);
            tick();
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
        chk("sb_drained", 64'(sbq.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
